// File: rtl/aes_ctr_pkg.sv
// Shared types and counter arithmetic for the AES-CTR controller.
package aes_ctr_pkg;

    localparam int unsigned BLOCK_W   = 128;
    localparam int unsigned CTR_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_ENC   = 2'd2,
        S_OUT   = 2'd3
    } ctr_state_e;

    // Returns {wrap, next_block}: only the low ctr_w bits step, the nonce is untouched.
    function automatic logic [BLOCK_W:0] ctr_step(input logic [BLOCK_W-1:0] blk,
                                                   input int unsigned       ctr_w);
        logic [BLOCK_W-1:0] mask;
        logic [BLOCK_W-1:0] inc;
        mask = {BLOCK_W{1'b1}} >> (BLOCK_W - ctr_w);
        inc  = blk + BLOCK_W'(1);
        return {&(blk | ~mask), (blk & ~mask) | (inc & mask)};
    endfunction

endpackage

// File: rtl/ctr_inc.sv
// Counter-field increment with wrap flag for a CTR_W-bit counter in a 128-bit block.
module ctr_inc
    import aes_ctr_pkg::*;
#(
    parameter int unsigned CTR_W = CTR_W_DEF
) (
    input  logic [BLOCK_W-1:0] blk_i,
    output logic [BLOCK_W-1:0] blk_o,
    output logic               wrap_o
);

    assign {wrap_o, blk_o} = ctr_step(blk_i, CTR_W);

endmodule

// File: rtl/ctr_mode_ctrl.sv
// AES-256-CTR controller: builds counter blocks, sequences the core, XORs keystream.
// Optional keystream prefetch buffer is enabled with `define CTR_PREFETCH_EN.
module ctr_mode_ctrl
    import aes_ctr_pkg::*;
#(
    parameter int unsigned CTR_W   = CTR_W_DEF,
    parameter int          KEY_LAT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] iv_i,
    input  logic               load_i,
    input  logic [BLOCK_W-1:0] data_i,
    input  logic               data_valid_i,
    output logic               data_ready_o,
    output logic [BLOCK_W-1:0] out_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [BLOCK_W-1:0] aes_block_o,
    output logic               aes_start_o,
    input  logic               aes_done_i,
    input  logic [BLOCK_W-1:0] aes_ks_i,
    output logic               ctr_wrap_o,
    output logic [1:0]         state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready is a pure function of registered state and valid never waits on ready.

    if (CTR_W < 8 || CTR_W > BLOCK_W || KEY_LAT < 0) begin : g_bad_param
        $error("ctr_mode_ctrl: illegal parameter value");
    end

    ctr_state_e         state_q, state_d;
    logic [BLOCK_W-1:0] ctr_q, ctr_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] out_q, out_d;
    logic               wrap_q, wrap_d;
    logic               start_q, start_d;
    logic               drop_q, drop_d;
    logic [BLOCK_W-1:0] ctr_inc_w;
    logic               inc_wrap_w;
`ifdef CTR_PREFETCH_EN
    logic [BLOCK_W-1:0] ks_q, ks_d;
    logic               ks_vld_q, ks_vld_d;
    logic               busy_q, busy_d;
    logic               pf_q, pf_d;
    logic               done_ok;
`endif

    ctr_inc #(.CTR_W(CTR_W)) u_ctr_inc (
        .blk_i  (ctr_q),
        .blk_o  (ctr_inc_w),
        .wrap_o (inc_wrap_w)
    );

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        data_d  = data_q;
        blk_d   = blk_q;
        out_d   = out_q;
        wrap_d  = wrap_q;
        start_d = 1'b0;
        drop_d  = drop_q;
`ifdef CTR_PREFETCH_EN
        ks_d     = ks_q;
        ks_vld_d = ks_vld_q;
        busy_d   = busy_q;
        pf_d     = pf_q;
        done_ok  = aes_done_i && busy_q && !drop_q && !load_i;
        if (aes_done_i && busy_q) begin
            busy_d = 1'b0;
            drop_d = 1'b0;
        end
        if (load_i && busy_q && !aes_done_i) drop_d = 1'b1;
        case (state_q)
            S_IDLE: if (load_i) begin
                state_d = S_READY;
                pf_d    = 1'b1;
            end
            S_READY: begin
                if (done_ok) begin
                    ks_d     = aes_ks_i;
                    ks_vld_d = 1'b1;
                end
                if (data_valid_i) begin
                    data_d  = data_i;
                    state_d = S_ENC;
                    pf_d    = 1'b0;
                    if (!load_i && (ks_vld_q || done_ok)) begin
                        out_d    = data_i ^ (ks_vld_q ? ks_q : aes_ks_i);
                        ctr_d    = ctr_inc_w;
                        wrap_d   = wrap_q | inc_wrap_w;
                        ks_vld_d = 1'b0;
                        state_d  = S_OUT;
                    end
                end else if (load_i) begin
                    pf_d = 1'b1;
                end
            end
            S_ENC: if (load_i) begin
                state_d = S_READY;
                pf_d    = 1'b1;
            end else if (done_ok) begin
                out_d   = data_q ^ aes_ks_i;
                ctr_d   = ctr_inc_w;
                wrap_d  = wrap_q | inc_wrap_w;
                state_d = S_OUT;
            end
            S_OUT: if (out_ready_i) begin
                state_d = S_READY;
                pf_d    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (load_i) begin
            ctr_d    = iv_i;
            wrap_d   = 1'b0;
            ks_vld_d = 1'b0;
        end
        // One scheduler covers both waiting data and speculative prefetch starts.
        if (!busy_d && (state_d == S_ENC || (state_d == S_READY && pf_d && !ks_vld_d))) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
            blk_d   = ctr_d;
            pf_d    = 1'b0;
        end
`else
        case (state_q)
            S_IDLE: if (load_i) state_d = S_READY;
            S_READY: if (data_valid_i) begin
                data_d  = data_i;
                blk_d   = load_i ? iv_i : ctr_q;
                start_d = 1'b1;
                state_d = S_ENC;
            end
            S_ENC: if (aes_done_i) begin
                drop_d = 1'b0;
                if (load_i || drop_q) begin
                    state_d = S_READY;
                end else begin
                    out_d   = data_q ^ aes_ks_i;
                    ctr_d   = ctr_inc_w;
                    wrap_d  = wrap_q | inc_wrap_w;
                    state_d = S_OUT;
                end
            end else if (load_i) begin
                drop_d = 1'b1;
            end
            S_OUT: if (out_ready_i) state_d = S_READY;
            default: state_d = S_IDLE;
        endcase
        if (load_i) begin
            ctr_d  = iv_i;
            wrap_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ctr_q   <= '0;
            data_q  <= '0;
            blk_q   <= '0;
            out_q   <= '0;
            wrap_q  <= 1'b0;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            data_q  <= data_d;
            blk_q   <= blk_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
            start_q <= start_d;
            drop_q  <= drop_d;
        end
    end

`ifdef CTR_PREFETCH_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ks_q     <= '0;
            ks_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            pf_q     <= 1'b0;
        end else begin
            ks_q     <= ks_d;
            ks_vld_q <= ks_vld_d;
            busy_q   <= busy_d;
            pf_q     <= pf_d;
        end
    end
`endif

    assign data_ready_o = (state_q == S_READY);
    assign out_valid_o  = (state_q == S_OUT);
    assign out_o        = out_q;
    assign aes_block_o  = blk_q;
    assign aes_start_o  = start_q;
    assign ctr_wrap_o   = wrap_q;
    assign state_o      = state_q;

endmodule

// File: doc/ctr_mode_ctrl.md
# ctr_mode_ctrl

AES-256-CTR mode controller sitting directly upstream and downstream of the `encryptiontop` AES core. It forms counter blocks (nonce ‖ counter) and hands each one to the core as its plaintext. It takes the returned keystream block and XORs it with the user data block, producing CTR ciphertext (or plaintext when decrypting). It owns the counter, the data/result handshakes and the core start/done sequencing; the key is driven to the core separately.

## Interface
Parameters:
- CTR_W, 32: width of the incrementing counter field (low bits of the 128-bit block); legal range 8..128.
- KEY_LAT, 0: informational only; the core's latency is not assumed, `aes_done_i` is used.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset (asserted when 0).
- iv_i  in  128  initial counter block; upper 128-CTR_W bits are the nonce, lower CTR_W bits are the start counter.
- load_i  in  1  one-cycle pulse; loads iv_i and clears the wrap flag.
- data_i  in  128  input data block.
- data_valid_i  in  1  data_i valid.
- data_ready_o  out  1  block can accept data_i.
- out_o  out  128  data_i XOR keystream.
- out_valid_o  out  1  out_o valid.
- out_ready_i  in  1  consumer accepts out_o.
- aes_block_o  out  128  counter block to the core's plaintext input.
- aes_start_o  out  1  one-cycle start pulse to the core.
- aes_done_i  in  1  one-cycle pulse; aes_ks_i valid.
- aes_ks_i  in  128  encrypted counter block (keystream).
- ctr_wrap_o  out  1  sticky; counter field wrapped since the last load.

## Operation
- States: IDLE (no IV), READY, ENC, OUT.
- IDLE: data_ready_o=0. load_i → READY.
- READY:
  - data_ready_o=1.
  - On data_valid_i && data_ready_o: capture data_i, drive aes_block_o=ctr, pulse aes_start_o next cycle, go to ENC.
- ENC:
  - aes_block_o held stable until aes_done_i.
  - On aes_done_i: out_o ← data_reg XOR aes_ks_i, out_valid_o=1, ctr ← ctr+1, go to OUT.
- Counter arithmetic:
  - Only the low CTR_W bits increment, modulo 2^CTR_W; the nonce bits never change.
  - Increment from all-ones → zero sets ctr_wrap_o.
- OUT:
  - out_o and out_valid_o held until out_ready_i.
  - On out_valid_o && out_ready_i → READY.
- load_i in READY/OUT: reloads ctr; state is otherwise unchanged.
- load_i in ENC:
  - ctr reloaded; a discard flag is set.
  - The in-flight aes_done_i is consumed with no output and no increment; then → READY.
- load_i and aes_done_i in the same cycle: load wins; the result is discarded.
- Reset values: out_o=0, out_valid_o=0, data_ready_o=0, aes_start_o=0, aes_block_o=0, ctr_wrap_o=0; state IDLE.
- Reset mid-operation: immediate return to IDLE. A later stray aes_done_i in IDLE is ignored.

## Timing
- Data accepted at edge t: aes_start_o high during cycle t+1.
- aes_done_i at cycle d: out_valid_o high from cycle d+1.
- Total latency is core latency + 2 cycles.
- With out_ready_i tied high, throughput is one block per core latency + 3 cycles (no prefetch).
- data_ready_o is registered; it never combinationally depends on data_valid_i.

## Configuration
CTR_PREFETCH_EN:
- Defined:
  - After load_i and after each OUT→READY, the controller starts the core on the current ctr without waiting for data.
  - The keystream is stored in a buffer with a valid flag.
  - Data arriving with a valid buffer yields out_valid_o the next cycle.
  - load_i invalidates the buffer (and discards any in-flight prefetch).
- Undefined: behaviour exactly as above; no buffer is present.

## Structure
- Shared package `aes_ctr_pkg`: state enum, BLOCK_W=128, the default CTR_W, and the counter-increment/wrap function.
- Optional sub-module `ctr_inc`: parameterised CTR_W increment with carry-out. Everything else is flat.

## Test plan
- Real core, key 000102…1f, iv 00112233445566778899aabbccddeeff, data 0 → out_o = 8ea2b7ca516745bfeafc49904b496089, ctr_wrap_o=0.
- Same setup, second block data 0 → aes_block_o = 00112233445566778899aabbccddef00 (CTR_W=32).
- iv low 32 bits ffffffff, one block → next aes_block_o low 32 bits 00000000, upper 96 bits unchanged, ctr_wrap_o=1. A following load_i clears it.
- out_ready_i low for 5 cycles after out_valid_o → out_o stable, data_ready_o=0 throughout, no second aes_start_o.
- load_i during ENC → the pending aes_done_i produces no out_valid_o, and the next block uses the newly loaded IV.
- rst low mid-ENC, then released → all outputs at reset values, state IDLE; data_valid_i is not accepted until load_i.
